// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32 byte/half/word data memory on a flop array, valid/ready on both sides.
// Define DMEM_INIT_WORD0_EN to reset word 0 to INIT_WORD0 (boot data pattern).
module data_mem_ctrl #(
    parameter int          ADDR_W      = 16,
    parameter int          DEPTH_WORDS = 32,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] INIT_WORD0  = 32'hBEEF_8080
) (
    input  logic              CK_REF,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_READ_WRN,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [2:0]        REQ_FUNCT3,
    input  logic [31:0]       REQ_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERR
);

`ifdef DMEM_INIT_WORD0_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    localparam logic [31:0]       WORD0_RST = INIT_WORD0 & {32{INIT_EN}};
    localparam int                IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int                WL        = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0]        WAIT_LAST = WL[3:0];
    localparam logic [ADDR_W-2:0] DEPTH_LIM = DEPTH_WORDS[ADDR_W-2:0];

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

    state_t            state_q, state_d;
    logic              ready_q;
    logic              accept, do_access;
    logic [3:0]        wcnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wdata_q;
    logic              read_q;
    logic [31:0]       mem [DEPTH_WORDS];
    logic [ADDR_W-3:0] widx;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic [31:0]       word, rd_ext, wr_lanes;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [3:0]        be;
    logic              bad_f3, misalign, out_range, err;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    assign widx      = addr_q[ADDR_W-1:2];
    assign idx       = widx[IDX_W-1:0];
    assign lane      = addr_q[1:0];
    assign word      = mem[idx];
    assign REQ_READY = ready_q;
    assign RSP_VALID = (state_q == ST_RESP);
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;

    // Decode the latched request: load extension, store lanes and error causes.
    always_comb begin
        rd_byte  = word[{lane, 3'b000} +: 8];
        rd_half  = lane[1] ? word[31:16] : word[15:0];
        rd_ext   = '0;
        be       = '0;
        wr_lanes = '0;
        bad_f3   = 1'b0;
        misalign = 1'b0;
        if (read_q) begin
            case (funct3_q)
                3'b000: rd_ext = {{24{rd_byte[7]}}, rd_byte};
                3'b100: rd_ext = {24'h0, rd_byte};
                3'b001: begin
                    rd_ext   = {{16{rd_half[15]}}, rd_half};
                    misalign = lane[0];
                end
                3'b101: begin
                    rd_ext   = {16'h0, rd_half};
                    misalign = lane[0];
                end
                3'b010: begin
                    rd_ext   = word;
                    misalign = |lane;
                end
                default: bad_f3 = 1'b1;
            endcase
        end else begin
            case (funct3_q)
                3'b000: begin
                    be       = 4'b0001 << lane;
                    wr_lanes = {4{wdata_q[7:0]}};
                end
                3'b001: begin
                    be       = lane[1] ? 4'b1100 : 4'b0011;
                    wr_lanes = {2{wdata_q[15:0]}};
                    misalign = lane[0];
                end
                3'b010: begin
                    be       = 4'hF;
                    wr_lanes = wdata_q;
                    misalign = |lane;
                end
                default: bad_f3 = 1'b1;
            endcase
        end
        out_range = {1'b0, widx} >= DEPTH_LIM;
        err       = bad_f3 | misalign | out_range;
    end

    // Next-state logic: accept in IDLE, count wait states, one access cycle, hold response.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        do_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID && ready_q) begin
                    accept  = 1'b1;
                    state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == WAIT_LAST) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                do_access = 1'b1;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (RSP_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, ready flag (low for one edge after reset), request latches and response.
    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            wcnt_q      <= '0;
            addr_q      <= '0;
            funct3_q    <= '0;
            wdata_q     <= '0;
            read_q      <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            if (accept) begin
                wcnt_q   <= '0;
                addr_q   <= REQ_ADDR;
                funct3_q <= REQ_FUNCT3;
                wdata_q  <= REQ_WDATA;
                read_q   <= REQ_READ_WRN;
            end else if (state_q == ST_WAIT) begin
                wcnt_q <= wcnt_q + 4'd1;
            end
            if (do_access) begin
                rsp_err_q   <= err;
                rsp_rdata_q <= (read_q && !err) ? rd_ext : '0;
            end
        end
    end

    // Word array: reset image, then byte-lane writes for legal stores in ACCESS.
    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= (i == 0) ? WORD0_RST : '0;
            end
        end else if (do_access && !read_q && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed requests, expected responses queued for a
// separate monitor that compares on each response handshake.
module tb_data_mem_ctrl;

    localparam int DEPTH = 32;
    localparam int WAITC = 1;
`ifdef DMEM_INIT_WORD0_EN
    localparam logic [31:0] WORD0 = 32'hBEEF_8080;
`else
    localparam logic [31:0] WORD0 = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_read_wrn = 1'b1;
    logic [15:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    data_mem_ctrl #(
        .ADDR_W(16),
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAITC),
        .INIT_WORD0(32'hBEEF_8080)
    ) dut (
        .CK_REF(clk),
        .RST_N(rst_n),
        .REQ_VALID(req_valid),
        .REQ_READY(req_ready),
        .REQ_READ_WRN(req_read_wrn),
        .REQ_ADDR(req_addr),
        .REQ_FUNCT3(req_funct3),
        .REQ_WDATA(req_wdata),
        .RSP_VALID(rsp_valid),
        .RSP_READY(rsp_ready),
        .RSP_RDATA(rsp_rdata),
        .RSP_ERR(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;

    function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void check1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endfunction

    // Monitor: compare every handshaked response against the scoreboard head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata %h err %b, expected no response",
                         rsp_rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                check32($sformatf("rsp%0d_rdata", e.id), rsp_rdata, e.rdata);
                check1($sformatf("rsp%0d_err", e.id), rsp_err, e.err);
            end
        end
    end

    task automatic issue(input logic rd, input logic [15:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input bit push, input bit timed);
        bit ok;
        int n;
        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        req_read_wrn = rd;
        req_addr     = addr;
        req_funct3   = f3;
        req_wdata    = wd;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: REQ_READY got 0, expected 1");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) sb.push_back('{er, ee, next_id});
        next_id++;
        #1;
        req_valid = 1'b0;
        if (timed) begin
            n  = 1;
            ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(posedge clk);
                #1;
                n++;
                if (rsp_valid) ok = 1'b1;
            end
            check32("latency_edges", n, WAITC + 2);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending responses, expected 0", sb.size());
        end
    endtask

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        #1;
        check1("rst_req_ready", req_ready, 1'b0);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check32("rst_rsp_rdata", rsp_rdata, 32'h0);
        check1("rst_rsp_err", rsp_err, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check1("req_ready_before_edge", req_ready, 1'b0);
        @(posedge clk);
        #1;
        check1("req_ready_first_edge", req_ready, 1'b1);

        // reset image of word 0, with latency measurement
        issue(1, 16'd0, 3'b010, 0, WORD0, 0, 1, 1);
        issue(0, 16'd0, 3'b010, 32'hBEEF_8080, 0, 0, 1, 0);
        // load extensions on BEEF_8080
        issue(1, 16'd3, 3'b000, 0, 32'hFFFF_FFBE, 0, 1, 0);
        issue(1, 16'd3, 3'b100, 0, 32'h0000_00BE, 0, 1, 0);
        issue(1, 16'd0, 3'b001, 0, 32'hFFFF_8080, 0, 1, 0);
        issue(1, 16'd2, 3'b101, 0, 32'h0000_BEEF, 0, 1, 0);
        issue(1, 16'd0, 3'b000, 0, 32'hFFFF_FF80, 0, 1, 0);
        issue(1, 16'd1, 3'b100, 0, 32'h0000_0080, 0, 1, 0);
        // byte / half stores merge into word 4
        issue(0, 16'd4, 3'b010, 32'h1234_5678, 0, 0, 1, 0);
        issue(0, 16'd5, 3'b000, 32'hFFFF_FFAB, 0, 0, 1, 0);
        issue(1, 16'd4, 3'b010, 0, 32'h1234_AB78, 0, 1, 0);
        issue(0, 16'd6, 3'b001, 32'h0000_CAFE, 0, 0, 1, 0);
        issue(1, 16'd4, 3'b010, 0, 32'hCAFE_AB78, 0, 1, 0);
        // errors: misaligned, out of range, undefined funct3
        issue(1, 16'd2, 3'b010, 0, 0, 1, 1, 0);
        issue(0, 16'd1, 3'b001, 32'h0000_FFFF, 0, 1, 1, 0);
        issue(1, 16'(4 * DEPTH), 3'b010, 0, 0, 1, 1, 0);
        issue(1, 16'd4, 3'b011, 0, 0, 1, 1, 0);
        issue(0, 16'd4, 3'b100, 32'h0, 0, 1, 1, 0);
        issue(1, 16'd3, 3'b001, 0, 0, 1, 1, 0);
        issue(0, 16'(4 * DEPTH), 3'b010, 32'h5555_5555, 0, 1, 1, 0);
        // memory unchanged by rejected accesses; last word is legal
        issue(1, 16'd4, 3'b010, 0, 32'hCAFE_AB78, 0, 1, 0);
        issue(1, 16'd0, 3'b010, 0, 32'hBEEF_8080, 0, 1, 0);
        issue(0, 16'(4 * DEPTH - 4), 3'b010, 32'h0000_0011, 0, 0, 1, 0);
        issue(1, 16'(4 * DEPTH - 4), 3'b010, 0, 32'h0000_0011, 0, 1, 0);
        drain();

        // response back-pressure; a request pulse in that window is ignored
        rsp_ready = 1'b0;
        issue(1, 16'd4, 3'b010, 0, 32'hCAFE_AB78, 0, 1, 0);
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 5; c++) begin
            check1("stall_rsp_valid", rsp_valid, 1'b1);
            check32("stall_rsp_rdata", rsp_rdata, 32'hCAFE_AB78);
            check1("stall_req_ready", req_ready, 1'b0);
            if (c == 1) begin
                req_valid    = 1'b1;
                req_read_wrn = 1'b0;
                req_addr     = 16'd12;
                req_funct3   = 3'b010;
                req_wdata    = 32'hDEAD_BEEF;
            end
            if (c == 2) req_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        drain();
        issue(1, 16'd12, 3'b010, 0, 32'h0, 0, 1, 0);
        drain();

        // reset during WAIT of a store: no write, array re-initialised
        issue(0, 16'd8, 3'b010, 32'hFFFF_FFFF, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check1("mid_rst_req_ready", req_ready, 1'b0);
        check1("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check32("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
        check1("mid_rst_rsp_err", rsp_err, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 16'd8, 3'b010, 0, 32'h0, 0, 1, 0);
        issue(1, 16'd4, 3'b010, 0, 32'h0, 0, 1, 0);
        issue(1, 16'd0, 3'b010, 0, WORD0, 0, 1, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
